lane_deskew_sched: RTL and testbench
====================================

Name: lane_deskew_sched

Overview:
- Read-side scheduler for the two-lane unstripe datapath. It buffers lane 0 and lane 1 words in one small FIFO per lane, absorbing inter-lane skew.
- It sequences reads strictly in the order lane0, lane1, lane0, … and emits a single merged 32-bit stream with a valid flag.
- It sits between the lane receivers and the downstream consumer, in the clk_2f domain.
- It detects skew timeouts and FIFO overflow, and reports them as sticky errors.

Parameters:
- WIDTH, 32, lane/data word width in bits.
- DEPTH, 4, entries per lane FIFO; must be a power of 2, ≥2.
- MAX_SKEW, 6, maximum consecutive cycles the scheduler may wait on one lane before declaring a skew error.

Ports:
- clk_2f  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- lane0  in  WIDTH  lane 0 data word.
- valid0  in  1  lane0 carries a word this cycle.
- lane1  in  WIDTH  lane 1 data word.
- valid1  in  1  lane1 carries a word this cycle.
- clear_err  in  1  synchronous clear of sticky error flags.
- dataOut  out  WIDTH  merged output word (registered).
- validOut  out  1  dataOut valid this cycle.
- err_skew  out  1  sticky skew-timeout flag.
- err_ovf  out  1  sticky overflow flag; set on a dropped write in either lane.
- state_o  out  2  current FSM state (debug).
- level0  out  clog2(DEPTH)+1  FIFO 0 occupancy.
- level1  out  clog2(DEPTH)+1  FIFO 1 occupancy.

Behaviour:
- Interface: one clock (clk_2f); reset is asynchronous and active-high.
- Reset values: dataOut=0, validOut=0, err_skew=0, err_ovf=0, state=IDLE, both FIFOs empty, skew counter=0.
- Reset asserted mid-stream discards all buffered words immediately.
- FIFO write:
  - validN=1 and FIFO N not full → write, even in the same cycle as a read.
  - validN=1, FIFO full and no same-cycle read → word dropped, err_ovf set.
  - Full with a same-cycle read is not overflow; the write succeeds.
- FSM states:
  - IDLE(0): waits until both FIFOs are non-empty, then goes to SEL0. No read.
  - SEL0(1): pops FIFO 0, goes to SEL1. If FIFO 0 is empty, goes to IDLE; this is a normal end of burst.
  - SEL1(2): if FIFO 1 is non-empty, pops it and goes to SEL0. If empty, stalls in SEL1 with no pop.
  - FLUSH(3): clears both FIFOs, sets err_skew, returns to IDLE next cycle. Writes arriving in FLUSH are discarded and do not set err_ovf.
- Skew counter:
  - Increments each cycle the FSM is in IDLE with exactly one FIFO non-empty, or is stalled in SEL1.
  - Clears on any pop and whenever that waiting condition is false.
  - On reaching MAX_SKEW, the next state is FLUSH, overriding all other transitions.
- Output timing:
  - A pop in cycle t drives dataOut/validOut=1 at the edge ending t.
  - Cycles without a pop give validOut=0 and dataOut=0.
  - Minimum latency from a word written in cycle t to validOut is 2 cycles: readable at t+1, visible after the t+1 edge.
- Ordering: output order is always L0[0], L1[0], L0[1], L1[1], …. A lane-1 word is never emitted before its lane-0 partner.
- Sustained throughput: one word per cycle when both lanes deliver one word every 2 cycles.
- Sticky flags:
  - clear_err=1 clears both flags on the next edge.
  - If an error event occurs in the same cycle as clear_err, the set wins.
- Counter widths:
  - level counters use clog2(DEPTH)+1 bits.
  - FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - The skew counter saturates at MAX_SKEW.

Decomposition:
- Package lane_sched_pkg:
  - FSM state encoding (IDLE, SEL0, SEL1, FLUSH).
  - Default WIDTH/DEPTH/MAX_SKEW constants.
- One natural sub-module, lane_fifo (parameterised WIDTH/DEPTH), instantiated twice. It has:
  - push/pop/flush inputs.
  - full/empty/level outputs.
  - an overflow pulse output.
- The top level holds the FSM, skew counter, output register and sticky flags.

Test Plan:
- Aligned burst: lane0 words 0xA0,0xA1 and lane1 words 0xB0,0xB1, both valid together every other cycle → dataOut sequence A0,B0,A1,B1 with validOut high for 4 words, first word 2 cycles after the first write, no errors.
- Skew within budget: lane1 lags lane0 by 3 cycles for 4-word bursts → same interleaved order, stalls in SEL1/IDLE, err_skew=0.
- Skew timeout: lane0 sends 0x11, lane1 silent → after MAX_SKEW=6 waiting cycles FLUSH, then err_skew=1, level0=0, no validOut.
- Overflow: lane0 writes 5 words while lane1 is silent (DEPTH=4) → 5th word dropped, err_ovf=1, level0=4. clear_err then clears err_ovf on the next edge.
- Full with simultaneous read: FIFO 0 full, pop and push in the same cycle → level0 stays 4, err_ovf=0, order preserved.
- Async reset mid-burst: assert reset between clock edges during streaming → outputs immediately 0, state_o=0, levels=0, and streaming restarts cleanly after deassertion.

Source files
------------

// File: rtl/lane_sched_pkg.sv
// Shared constants and FSM encoding for the two-lane deskew read scheduler.
package lane_sched_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int DEPTH_DEF    = 4;
  localparam int MAX_SKEW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL0  = 2'd1,
    SEL1  = 2'd2,
    FLUSH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane skew buffer: power-of-two circular FIFO with flush and a drop (overflow) pulse.
module lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign ovf     = push && full && !do_pop && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lane_deskew_sched.sv
// Merges two skewed lanes into one stream in strict lane0/lane1 order, with skew
// timeout and overflow detection reported as sticky error flags.
module lane_deskew_sched
  import lane_sched_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_SKEW = MAX_SKEW_DEF
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       lane0,
  input  logic                   valid0,
  input  logic [WIDTH-1:0]       lane1,
  input  logic                   valid1,
  input  logic                   clear_err,
  output logic [WIDTH-1:0]       dataOut,
  output logic                   validOut,
  output logic                   err_skew,
  output logic                   err_ovf,
  output logic [1:0]             state_o,
  output logic [$clog2(DEPTH):0] level0,
  output logic [$clog2(DEPTH):0] level1
);

  localparam int SW = $clog2(MAX_SKEW + 1);

  sched_state_t     state, state_nxt;
  logic [SW-1:0]    skew, skew_nxt;
  logic             pop0, pop1, flush, waiting;
  logic             full0, full1, empty0, empty1, ovf0, ovf1;
  logic [WIDTH-1:0] dout0, dout1;

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk_2f), .rst(reset), .push(valid0), .din(lane0), .pop(pop0), .flush(flush),
    .dout(dout0), .full(full0), .empty(empty0), .level(level0), .ovf(ovf0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk_2f), .rst(reset), .push(valid1), .din(lane1), .pop(pop1), .flush(flush),
    .dout(dout1), .full(full1), .empty(empty1), .level(level1), .ovf(ovf1)
  );

  assign state_o = state;

  always_comb begin
    state_nxt = state;
    pop0      = 1'b0;
    pop1      = 1'b0;
    flush     = 1'b0;
    waiting   = 1'b0;
    case (state)
      IDLE: begin
        waiting = empty0 ^ empty1;
        if (!empty0 && !empty1) state_nxt = SEL0;
      end
      SEL0: begin
        if (!empty0) begin
          pop0      = 1'b1;
          state_nxt = SEL1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEL1: begin
        if (!empty1) begin
          pop1      = 1'b1;
          state_nxt = SEL0;
        end else begin
          waiting = 1'b1;
        end
      end
      default: begin
        flush     = 1'b1;
        state_nxt = IDLE;
      end
    endcase
    // Waiting never coincides with a pop, so the timeout override cannot lose a word.
    if (!waiting)                       skew_nxt = '0;
    else if (skew == SW'(MAX_SKEW))     skew_nxt = skew;
    else                                skew_nxt = skew + 1'b1;
    if (skew_nxt == SW'(MAX_SKEW)) state_nxt = FLUSH;
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      skew     <= '0;
      dataOut  <= '0;
      validOut <= 1'b0;
      err_skew <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      state <= state_nxt;
      skew  <= skew_nxt;
      if (pop0) begin
        dataOut  <= dout0;
        validOut <= 1'b1;
      end else if (pop1) begin
        dataOut  <= dout1;
        validOut <= 1'b1;
      end else begin
        dataOut  <= '0;
        validOut <= 1'b0;
      end
      // Error events take priority over a same-cycle clear.
      if (state == FLUSH)  err_skew <= 1'b1;
      else if (clear_err)  err_skew <= 1'b0;
      if (ovf0 || ovf1)    err_ovf  <= 1'b1;
      else if (clear_err)  err_ovf  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_deskew_sched.sv
// Scenario bench for lane_deskew_sched: directed timing checks plus randomized skewed bursts
// scored against the expected interleaved word order.
module tb_lane_deskew_sched;

  localparam int MAX_SKEW = 6;
  localparam int DEPTH    = 4;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] lane0, lane1;
  logic        valid0, valid1, clear_err;
  logic [31:0] dataOut;
  logic        validOut, err_skew, err_ovf;
  logic [1:0]  state_o;
  logic [2:0]  level0, level1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  lane_deskew_sched dut (
    .clk_2f(clk_2f), .reset(reset),
    .lane0(lane0), .valid0(valid0), .lane1(lane1), .valid1(valid1),
    .clear_err(clear_err),
    .dataOut(dataOut), .validOut(validOut), .err_skew(err_skew), .err_ovf(err_ovf),
    .state_o(state_o), .level0(level0), .level1(level1)
  );

  // clock / reset
  always #5 clk_2f = ~clk_2f;

  // output monitor
  always @(posedge clk_2f) begin
    #1;
    if (validOut) obs_q.push_back(dataOut);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input logic v0, input logic [31:0] d0,
                      input logic v1, input logic [31:0] d1, input logic clr);
    valid0 = v0; lane0 = d0; valid1 = v1; lane1 = d1; clear_err = clr;
    @(posedge clk_2f);
    #2;
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    valid0 = 0; valid1 = 0; lane0 = 0; lane1 = 0; clear_err = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk_2f);
    #2;
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Lane 0 sends a word every 2 cycles; lane 1 sends its partner 'lag' cycles later.
  task automatic run_burst(input int n, input int lag);
    logic [31:0] a [$];
    logic [31:0] b [$];
    int guard;
    for (int i = 0; i < n; i++) begin
      a.push_back($urandom());
      b.push_back($urandom());
      exp_q.push_back(a[i]);
      exp_q.push_back(b[i]);
    end
    for (int c = 0; c <= 2 * (n - 1) + lag; c++) begin
      logic v0, v1;
      v0 = (c % 2 == 0) && (c / 2 < n);
      v1 = (c >= lag) && ((c - lag) % 2 == 0) && ((c - lag) / 2 < n);
      tick(v0, v0 ? a[c / 2] : 32'h0, v1, v1 ? b[(c - lag) / 2] : 32'h0, 1'b0);
    end
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 40) begin
      idle();
      guard++;
    end
    repeat (3) idle();
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 7;
    if (dataOut  !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %0h expected 0", dataOut); end
    if (validOut !== 1'b0)  begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", validOut); end
    if (err_skew !== 1'b0)  begin miscompares++; $display("FAIL reset_err_skew: got %0b expected 0", err_skew); end
    if (err_ovf  !== 1'b0)  begin miscompares++; $display("FAIL reset_err_ovf: got %0b expected 0", err_ovf); end
    if (state_o  !== 2'd0)  begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    if (level0   !== 3'd0)  begin miscompares++; $display("FAIL reset_level0: got %0d expected 0", level0); end
    if (level1   !== 3'd0)  begin miscompares++; $display("FAIL reset_level1: got %0d expected 0", level1); end
  endtask

  task automatic test_aligned();
    logic        exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_d [7] = '{32'h0, 32'h0, 32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'h0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      tick(1'b1, 32'hA0, 1'b1, 32'hB0, 1'b0);
      else if (k == 2) tick(1'b1, 32'hA1, 1'b1, 32'hB1, 1'b0);
      else             idle();
      vectors += 2;
      if (validOut !== exp_v[k]) begin
        miscompares++; $display("FAIL aligned_valid[%0d]: got %0b expected %0b", k, validOut, exp_v[k]);
      end
      if (dataOut !== exp_d[k]) begin
        miscompares++; $display("FAIL aligned_data[%0d]: got %0h expected %0h", k, dataOut, exp_d[k]);
      end
    end
    vectors++;
    if ({err_skew, err_ovf} !== 2'b00) begin
      miscompares++; $display("FAIL aligned_errors: got %b expected 00", {err_skew, err_ovf});
    end
  endtask

  task automatic test_skew_ok();
    do_reset();
    run_burst(4, 3);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL skew_ok_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL skew_ok_word[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (err_skew !== 1'b0) begin miscompares++; $display("FAIL skew_ok_err: got %0b expected 0", err_skew); end
  endtask

  task automatic test_skew_timeout();
    do_reset();
    tick(1'b1, 32'h11, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= MAX_SKEW + 1; k++) begin
      logic [1:0] es;
      logic [2:0] el;
      logic       ee;
      idle();
      es = (k == MAX_SKEW) ? 2'd3 : 2'd0;
      el = (k > MAX_SKEW) ? 3'd0 : 3'd1;
      ee = (k > MAX_SKEW);
      vectors += 4;
      if (state_o !== es) begin miscompares++; $display("FAIL timeout_state[%0d]: got %0d expected %0d", k, state_o, es); end
      if (level0 !== el)  begin miscompares++; $display("FAIL timeout_level0[%0d]: got %0d expected %0d", k, level0, el); end
      if (err_skew !== ee) begin miscompares++; $display("FAIL timeout_err[%0d]: got %0b expected %0b", k, err_skew, ee); end
      if (validOut !== 1'b0) begin miscompares++; $display("FAIL timeout_valid[%0d]: got 1 expected 0", k); end
    end
    repeat (2) idle();
    vectors++;
    if (err_skew !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %0b expected 1", err_skew); end
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vectors++;
    if (err_skew !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %0b expected 0", err_skew); end
  endtask

  task automatic test_overflow();
    do_reset();
    // Sixth write overflows again while clear_err is high: the set must win.
    for (int k = 0; k < 6; k++) begin
      logic [2:0] el;
      logic       eo;
      tick(1'b1, 32'hC0 + k, 1'b0, 32'h0, k == 5);
      el = (k + 1 > DEPTH) ? 3'(DEPTH) : 3'(k + 1);
      eo = (k >= DEPTH);
      vectors += 2;
      if (level0 !== el)  begin miscompares++; $display("FAIL ovf_level0[%0d]: got %0d expected %0d", k, level0, el); end
      if (err_ovf !== eo) begin miscompares++; $display("FAIL ovf_flag[%0d]: got %0b expected %0b", k, err_ovf, eo); end
    end
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vectors += 2;
    if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %0b expected 0", err_ovf); end
    if (state_o !== 2'd3) begin miscompares++; $display("FAIL ovf_flush_state: got %0d expected 3", state_o); end
    idle();
    vectors += 2;
    if (level0 !== 3'd0)   begin miscompares++; $display("FAIL ovf_flushed_level: got %0d expected 0", level0); end
    if (err_skew !== 1'b1) begin miscompares++; $display("FAIL ovf_flush_err: got %0b expected 1", err_skew); end
  endtask

  task automatic test_full_read();
    int guard;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'hA0 + i);
      exp_q.push_back(32'hB0 + i);
    end
    for (int k = 0; k < 4; k++) tick(1'b1, 32'hA0 + k, k == 3, 32'hB0, 1'b0);
    idle();
    vectors++;
    if (level0 !== 3'd4) begin miscompares++; $display("FAIL full_level_before: got %0d expected 4", level0); end
    tick(1'b1, 32'hA4, 1'b1, 32'hB1, 1'b0);
    vectors += 2;
    if (level0 !== 3'd4)  begin miscompares++; $display("FAIL full_level_rw: got %0d expected 4", level0); end
    if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL full_rw_ovf: got %0b expected 0", err_ovf); end
    for (int k = 2; k < 5; k++) tick(1'b0, 32'h0, 1'b1, 32'hB0 + k, 1'b0);
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 40) begin idle(); guard++; end
    repeat (3) idle();
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL full_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL full_word[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 32'h1, 1'b1, 32'h2, 1'b0);
    idle();
    tick(1'b1, 32'h3, 1'b1, 32'h4, 1'b0);
    idle();
    vectors++;
    if (validOut !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %0b expected 1", validOut); end
    #3;
    reset = 1'b1;
    #1;
    vectors += 5;
    if (dataOut !== 32'h0) begin miscompares++; $display("FAIL mid_data: got %0h expected 0", dataOut); end
    if (validOut !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %0b expected 0", validOut); end
    if (state_o !== 2'd0)  begin miscompares++; $display("FAIL mid_state: got %0d expected 0", state_o); end
    if (level0 !== 3'd0)   begin miscompares++; $display("FAIL mid_level0: got %0d expected 0", level0); end
    if (level1 !== 3'd0)   begin miscompares++; $display("FAIL mid_level1: got %0d expected 0", level1); end
    #2;
    reset = 1'b0;
    idle();
    exp_q.delete();
    obs_q.delete();
    run_burst(3, 1);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL mid_restart_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL mid_restart_word[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int b = 0; b < 16; b++) begin
      int n, lag;
      n   = $urandom_range(1, 6);
      lag = $urandom_range(0, 3);
      exp_q.delete();
      obs_q.delete();
      run_burst(n, lag);
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
        miscompares++; $display("FAIL rand_count[%0d]: got %0d expected %0d", b, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand_word[%0d.%0d]: got %0h expected %0h", b, i, obs_q[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if ({err_skew, err_ovf} !== 2'b00) begin
      miscompares++; $display("FAIL rand_errors: got %b expected 00", {err_skew, err_ovf});
    end
  endtask

  // scenario sequence and final report
  initial begin
    reset = 1'b1;
    valid0 = 0; valid1 = 0; lane0 = 0; lane1 = 0; clear_err = 0;
    test_reset();
    test_aligned();
    test_skew_ok();
    test_skew_timeout();
    test_overflow();
    test_full_read();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
